// File: rtl/riscv_uc_pkg.sv
// Shared definitions for the RV64I multicycle control unit: opcodes, FSM states,
// register-file write-back source codes and small state helpers.
package riscv_uc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_R32    = 7'b0111011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_I32    = 7'b0011011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RF_SEL_DATA  = 2'b00;
    localparam logic [1:0] RF_SEL_ULA   = 2'b01;
    localparam logic [1:0] RF_SEL_PC4   = 2'b10;
    localparam logic [1:0] RF_SEL_PCADD = 2'b11;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_ALU = 4'd2,
        AUIPC    = 4'd3,
        MEM_LD   = 4'd4,
        MEM_ST   = 4'd5,
        BRANCH   = 4'd6,
        JAL      = 4'd7,
        JALR     = 4'd8,
        HALT     = 4'd9
    } uc_state_e;

    // States that hold a request on the unified memory and wait for mem_ready.
    function automatic logic is_mem_state(input uc_state_e state);
        return (state == FETCH) || (state == MEM_LD) || (state == MEM_ST);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Unified-memory request/ready handshake between the control unit and the memory.
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/uc_opcode_decoder.sv
// Classifies the IR opcode into the execute/memory state that follows DECODE.
module uc_opcode_decoder
    import riscv_uc_pkg::*;
(
    input  logic [6:0] opcode,
    output uc_state_e  next_state,
    output logic       alu_imm,
    output logic       illegal
);

    // Opcode classification; unknown encodings are flagged and steer to HALT
    always_comb begin
        next_state = HALT;
        alu_imm    = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP_R, OP_R32: next_state = EXEC_ALU;
            OP_I, OP_I32, OP_LUI: begin
                next_state = EXEC_ALU;
                alu_imm    = 1'b1;
            end
            OP_LOAD:   next_state = MEM_LD;
            OP_STORE:  next_state = MEM_ST;
            OP_BRANCH: next_state = BRANCH;
            OP_JAL:    next_state = JAL;
            OP_JALR:   next_state = JALR;
            OP_AUIPC:  next_state = AUIPC;
            default: begin
                next_state = HALT;
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV64I control FSM: fetch/decode/execute sequencing over a ready-handshaked
// memory, memory wait timeout, retired-instruction counter and sticky halt status.
module multicycle_control_unit
    import riscv_uc_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 255
)
(
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [6:0]                opcode,
    multicycle_control_unit_if.master mem,
    output logic                      WE_RF,
    output logic [1:0]                RF_din_sel,
    output logic                      ULA_din2_sel,
    output logic                      addr_sel,
    output logic                      load_pc,
    output logic                      load_ir,
    output logic                      pc_next_sel,
    output logic                      pc_adder_sel,
    output logic                      halted,
    output logic                      bus_error,
    output logic [CNT_WIDTH-1:0]      retired
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

    uc_state_e              state_r;
    uc_state_e              state_next_s;
    uc_state_e              dec_state_s;
    logic                   dec_alu_imm_s;
    logic                   dec_illegal_s;
    logic                   timeout_s;
    logic [WAIT_W-1:0]      wait_cnt_r;
    logic [CNT_WIDTH-1:0]   retired_r;
    logic                   halted_r;
    logic                   bus_error_r;

    logic                   mem_req_s;
    logic                   mem_we_s;
    logic                   we_rf_s;
    logic [1:0]             rf_din_sel_s;
    logic                   ula_din2_sel_s;
    logic                   addr_sel_s;
    logic                   load_pc_s;
    logic                   load_ir_s;
    logic                   pc_next_sel_s;
    logic                   pc_adder_sel_s;

    uc_opcode_decoder u_decoder (
        .opcode     (opcode),
        .next_state (dec_state_s),
        .alu_imm    (dec_alu_imm_s),
        .illegal    (dec_illegal_s)
    );

    // Next-state logic; a ready on the timeout cycle still completes normally
    always_comb begin
        state_next_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            FETCH, MEM_LD, MEM_ST: begin
                if (mem.mem_ready) begin
                    state_next_s = (state_r == FETCH) ? DECODE : FETCH;
                end else if (wait_cnt_r == TIMEOUT_C) begin
                    state_next_s = HALT;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            DECODE: begin
                if (dec_illegal_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = dec_state_s;
                end
            end
            EXEC_ALU, AUIPC, BRANCH, JAL, JALR: state_next_s = FETCH;
            HALT:    state_next_s = HALT;
            default: state_next_s = HALT;
        endcase
    end

    // State-decoded strobes; all forced low while reset is asserted
    always_comb begin
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        we_rf_s        = 1'b0;
        rf_din_sel_s   = RF_SEL_DATA;
        ula_din2_sel_s = 1'b0;
        addr_sel_s     = 1'b0;
        load_pc_s      = 1'b0;
        load_ir_s      = 1'b0;
        pc_next_sel_s  = 1'b0;
        pc_adder_sel_s = 1'b0;
        if (reset) begin
            mem_req_s = 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    mem_req_s  = 1'b1;
                    addr_sel_s = 1'b1;
                    load_ir_s  = mem.mem_ready;
                end
                EXEC_ALU: begin
                    we_rf_s        = 1'b1;
                    rf_din_sel_s   = RF_SEL_ULA;
                    ula_din2_sel_s = dec_alu_imm_s;
                    load_pc_s      = 1'b1;
                end
                AUIPC: begin
                    we_rf_s      = 1'b1;
                    rf_din_sel_s = RF_SEL_PCADD;
                    load_pc_s    = 1'b1;
                end
                MEM_LD: begin
                    mem_req_s      = 1'b1;
                    ula_din2_sel_s = 1'b1;
                    we_rf_s        = mem.mem_ready;
                    rf_din_sel_s   = RF_SEL_DATA;
                    load_pc_s      = mem.mem_ready;
                end
                MEM_ST: begin
                    mem_req_s      = 1'b1;
                    mem_we_s       = 1'b1;
                    ula_din2_sel_s = 1'b1;
                    load_pc_s      = mem.mem_ready;
                end
                BRANCH: begin
                    load_pc_s     = 1'b1;
                    pc_next_sel_s = 1'b1;
                end
                JAL, JALR: begin
                    we_rf_s        = 1'b1;
                    rf_din_sel_s   = RF_SEL_PC4;
                    load_pc_s      = 1'b1;
                    pc_next_sel_s  = 1'b1;
                    pc_adder_sel_s = (state_r == JALR);
                end
                DECODE:  mem_req_s = 1'b0;
                HALT:    mem_req_s = 1'b0;
                default: mem_req_s = 1'b0;
            endcase
        end
    end

    // State, memory wait counter, retired counter and sticky halt status
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r     <= FETCH;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            retired_r   <= {CNT_WIDTH{1'b0}};
            halted_r    <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (is_mem_state(state_r) && !mem.mem_ready) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (load_pc_s) begin
                retired_r <= retired_r + CNT_WIDTH'(1'b1);
            end
            if (state_next_s == HALT) begin
                halted_r <= 1'b1;
            end
            if (timeout_s) begin
                bus_error_r <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = mem_req_s;
    assign mem.mem_we    = mem_we_s;
    assign WE_RF         = we_rf_s;
    assign RF_din_sel    = rf_din_sel_s;
    assign ULA_din2_sel  = ula_din2_sel_s;
    assign addr_sel      = addr_sel_s;
    assign load_pc       = load_pc_s;
    assign load_ir       = load_ir_s;
    assign pc_next_sel   = pc_next_sel_s;
    assign pc_adder_sel  = pc_adder_sel_s;
    assign halted        = halted_r;
    assign bus_error     = bus_error_r;
    assign retired       = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (MEM_TIMEOUT=4, 4-bit retired counter).
module tb_multicycle_control_unit;

    localparam int CW = 4;

    // Strobe vector layout: mem_req mem_we WE_RF RF_din_sel[1:0] ULA_din2_sel addr_sel load_pc load_ir pc_next_sel pc_adder_sel
    localparam logic [10:0] S_IDLE    = 11'b0_0_0_00_0_0_0_0_0_0;
    localparam logic [10:0] S_FETCH   = 11'b1_0_0_00_0_1_0_0_0_0;
    localparam logic [10:0] S_FETCH_R = 11'b1_0_0_00_0_1_0_1_0_0;
    localparam logic [10:0] S_ALU_I   = 11'b0_0_1_01_1_0_1_0_0_0;
    localparam logic [10:0] S_ALU_R   = 11'b0_0_1_01_0_0_1_0_0_0;
    localparam logic [10:0] S_AUIPC   = 11'b0_0_1_11_0_0_1_0_0_0;
    localparam logic [10:0] S_LD_W    = 11'b1_0_0_00_1_0_0_0_0_0;
    localparam logic [10:0] S_LD_R    = 11'b1_0_1_00_1_0_1_0_0_0;
    localparam logic [10:0] S_ST_W    = 11'b1_1_0_00_1_0_0_0_0_0;
    localparam logic [10:0] S_ST_R    = 11'b1_1_0_00_1_0_1_0_0_0;
    localparam logic [10:0] S_BR      = 11'b0_0_0_00_0_0_1_0_1_0;
    localparam logic [10:0] S_JAL     = 11'b0_0_1_10_0_0_1_0_1_0;
    localparam logic [10:0] S_JALR    = 11'b0_0_1_10_0_0_1_0_1_1;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b0000000;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = 7'b0;
    logic          WE_RF, ULA_din2_sel, addr_sel, load_pc, load_ir;
    logic          pc_next_sel, pc_adder_sel, halted, bus_error;
    logic [1:0]    RF_din_sel;
    logic [CW-1:0] retired;
    logic [10:0]   strobes;
    int            n_cmp = 0;
    int            n_bad = 0;

    logic [6:0]  b2b_op  [7] = '{7'b0110011, 7'b0011011, 7'b0110111, 7'b0111011,
                                 7'b0010111, 7'b1100011, 7'b1101111};
    logic [10:0] b2b_exp [7] = '{S_ALU_R, S_ALU_I, S_ALU_I, S_ALU_R, S_AUIPC, S_BR, S_JAL};

    multicycle_control_unit_if mif ();

    multicycle_control_unit #(.CNT_WIDTH(CW), .MEM_TIMEOUT(4)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .opcode       (opcode),
        .mem          (mif),
        .WE_RF        (WE_RF),
        .RF_din_sel   (RF_din_sel),
        .ULA_din2_sel (ULA_din2_sel),
        .addr_sel     (addr_sel),
        .load_pc      (load_pc),
        .load_ir      (load_ir),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .halted       (halted),
        .bus_error    (bus_error),
        .retired      (retired)
    );

    assign strobes = {mif.mem_req, mif.mem_we, WE_RF, RF_din_sel, ULA_din2_sel, addr_sel,
                      load_pc, load_ir, pc_next_sel, pc_adder_sel};

    always #5 CLK = ~CLK;

    task automatic apply_reset();
        @(negedge CLK);
        reset = 1'b1;
        mif.mem_ready = 1'b0;
        @(posedge CLK);
    endtask

    // One clock cycle with reset released; outputs settle 1 time unit after the negedge.
    task automatic cycle_in(input logic [6:0] op, input logic rdy);
        @(negedge CLK);
        reset = 1'b0;
        opcode = op;
        mif.mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge CLK);
        #1;
        n_cmp++; if (strobes !== S_IDLE) begin n_bad++; $display("FAIL reset_strobes: got %b want %b", strobes, S_IDLE); end
        n_cmp++; if (retired !== 4'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
        n_cmp++; if ({halted, bus_error} !== 2'b00) begin n_bad++; $display("FAIL reset_status: got %b want 00", {halted, bus_error}); end
        cycle_in(OP_ADDI, 1'b0);
        n_cmp++; if (strobes !== S_FETCH) begin n_bad++; $display("FAIL reset_first_fetch: got %b want %b", strobes, S_FETCH); end
    endtask

    task automatic test_addi();
        apply_reset();
        cycle_in(OP_ADDI, 1'b1);
        n_cmp++; if (strobes !== S_FETCH_R) begin n_bad++; $display("FAIL addi_c0: got %b want %b", strobes, S_FETCH_R); end
        cycle_in(OP_ADDI, 1'b1);
        n_cmp++; if (strobes !== S_IDLE) begin n_bad++; $display("FAIL addi_decode: got %b want %b", strobes, S_IDLE); end
        cycle_in(OP_ADDI, 1'b0);
        n_cmp++; if (strobes !== S_ALU_I) begin n_bad++; $display("FAIL addi_c2: got %b want %b", strobes, S_ALU_I); end
        n_cmp++; if (retired !== 4'd0) begin n_bad++; $display("FAIL addi_retired_c2: got %0d want 0", retired); end
        cycle_in(OP_ADDI, 1'b0);
        n_cmp++; if (retired !== 4'd1) begin n_bad++; $display("FAIL addi_retired_c3: got %0d want 1", retired); end
        n_cmp++; if (strobes !== S_FETCH) begin n_bad++; $display("FAIL addi_c3_fetch: got %b want %b", strobes, S_FETCH); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            cycle_in(b2b_op[i], 1'b1);
            n_cmp++; if (strobes !== S_FETCH_R) begin n_bad++; $display("FAIL b2b_fetch[%0d]: got %b want %b", i, strobes, S_FETCH_R); end
            cycle_in(b2b_op[i], 1'b0);
            cycle_in(b2b_op[i], 1'b0);
            n_cmp++; if (strobes !== b2b_exp[i]) begin n_bad++; $display("FAIL b2b_exec[%0d]: got %b want %b", i, strobes, b2b_exp[i]); end
        end
        cycle_in(OP_ADDI, 1'b0);
        n_cmp++; if (retired !== 4'd7) begin n_bad++; $display("FAIL b2b_retired: got %0d want 7", retired); end
    endtask

    task automatic test_load();
        apply_reset();
        cycle_in(OP_LD, 1'b1);
        cycle_in(OP_LD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle_in(OP_LD, 1'b0);
            n_cmp++; if (strobes !== S_LD_W) begin n_bad++; $display("FAIL ld_wait[%0d]: got %b want %b", i, strobes, S_LD_W); end
        end
        cycle_in(OP_LD, 1'b1);
        n_cmp++; if (strobes !== S_LD_R) begin n_bad++; $display("FAIL ld_ready: got %b want %b", strobes, S_LD_R); end
        cycle_in(OP_LD, 1'b0);
        n_cmp++; if (strobes !== S_FETCH || retired !== 4'd1) begin n_bad++; $display("FAIL ld_after: got %b/%0d want %b/1", strobes, retired, S_FETCH); end
    endtask

    task automatic test_store();
        apply_reset();
        cycle_in(OP_SD, 1'b1);
        cycle_in(OP_SD, 1'b0);
        cycle_in(OP_SD, 1'b0);
        n_cmp++; if (strobes !== S_ST_W) begin n_bad++; $display("FAIL st_wait: got %b want %b", strobes, S_ST_W); end
        cycle_in(OP_SD, 1'b1);
        n_cmp++; if (strobes !== S_ST_R) begin n_bad++; $display("FAIL st_ready: got %b want %b", strobes, S_ST_R); end
        cycle_in(OP_SD, 1'b0);
        n_cmp++; if (strobes !== S_FETCH || retired !== 4'd1) begin n_bad++; $display("FAIL st_after: got %b/%0d want %b/1", strobes, retired, S_FETCH); end
    endtask

    task automatic test_jalr();
        apply_reset();
        cycle_in(OP_JALR, 1'b1);
        cycle_in(OP_JALR, 1'b0);
        cycle_in(OP_JALR, 1'b0);
        n_cmp++; if (strobes !== S_JALR) begin n_bad++; $display("FAIL jalr_exec: got %b want %b", strobes, S_JALR); end
        cycle_in(OP_JALR, 1'b0);
        n_cmp++; if (strobes !== S_FETCH || retired !== 4'd1) begin n_bad++; $display("FAIL jalr_one_cycle: got %b/%0d want %b/1", strobes, retired, S_FETCH); end
    endtask

    task automatic test_illegal();
        apply_reset();
        cycle_in(OP_ADDI, 1'b1);
        cycle_in(OP_ADDI, 1'b0);
        cycle_in(OP_ADDI, 1'b0);
        cycle_in(OP_BAD, 1'b1);
        cycle_in(OP_BAD, 1'b0);
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL ill_decode_halted: got %b want 0", halted); end
        for (int i = 0; i < 3; i++) begin
            cycle_in(OP_BAD, 1'b1);
            n_cmp++; if (strobes !== S_IDLE || retired !== 4'd1) begin n_bad++; $display("FAIL ill_frozen[%0d]: got %b/%0d want %b/1", i, strobes, retired, S_IDLE); end
        end
        n_cmp++; if ({halted, bus_error} !== 2'b10) begin n_bad++; $display("FAIL ill_status: got %b want 10", {halted, bus_error}); end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cycle_in(OP_ADDI, 1'b0);
            n_cmp++; if (strobes !== S_FETCH || halted !== 1'b0) begin n_bad++; $display("FAIL to_fetch[%0d]: got %b/%b want %b/0", i, strobes, halted, S_FETCH); end
        end
        cycle_in(OP_ADDI, 1'b1);
        n_cmp++; if (strobes !== S_IDLE) begin n_bad++; $display("FAIL to_halt_strobes: got %b want %b", strobes, S_IDLE); end
        n_cmp++; if ({halted, bus_error} !== 2'b11) begin n_bad++; $display("FAIL to_status: got %b want 11", {halted, bus_error}); end
    endtask

    task automatic test_timeout_boundary();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle_in(OP_ADDI, 1'b0);
        end
        cycle_in(OP_ADDI, 1'b1);
        n_cmp++; if (strobes !== S_FETCH_R) begin n_bad++; $display("FAIL tob_ready_wins: got %b want %b", strobes, S_FETCH_R); end
        cycle_in(OP_ADDI, 1'b0);
        n_cmp++; if ({halted, bus_error} !== 2'b00) begin n_bad++; $display("FAIL tob_status: got %b want 00", {halted, bus_error}); end
        cycle_in(OP_ADDI, 1'b0);
        n_cmp++; if (strobes !== S_ALU_I) begin n_bad++; $display("FAIL tob_exec: got %b want %b", strobes, S_ALU_I); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cycle_in(OP_ADDI, 1'b1);
        cycle_in(OP_ADDI, 1'b0);
        cycle_in(OP_ADDI, 1'b0);
        cycle_in(OP_LD, 1'b1);
        cycle_in(OP_LD, 1'b0);
        cycle_in(OP_LD, 1'b0);
        n_cmp++; if (strobes !== S_LD_W) begin n_bad++; $display("FAIL rmid_in_ld: got %b want %b", strobes, S_LD_W); end
        @(negedge CLK);
        reset = 1'b1;
        mif.mem_ready = 1'b1;
        #1;
        n_cmp++; if (strobes !== S_IDLE) begin n_bad++; $display("FAIL rmid_reset_cycle: got %b want %b", strobes, S_IDLE); end
        @(posedge CLK);
        cycle_in(OP_LD, 1'b0);
        n_cmp++; if (strobes !== S_FETCH || retired !== 4'd0) begin n_bad++; $display("FAIL rmid_after: got %b/%0d want %b/0", strobes, retired, S_FETCH); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            cycle_in(OP_ADDI, 1'b1);
            cycle_in(OP_ADDI, 1'b0);
            cycle_in(OP_ADDI, 1'b0);
        end
        cycle_in(OP_ADDI, 1'b1);
        n_cmp++; if (retired !== 4'd15) begin n_bad++; $display("FAIL wrap_15: got %0d want 15", retired); end
        cycle_in(OP_ADDI, 1'b0);
        cycle_in(OP_ADDI, 1'b0);
        cycle_in(OP_ADDI, 1'b0);
        n_cmp++; if (retired !== 4'd0) begin n_bad++; $display("FAIL wrap_0: got %0d want 0", retired); end
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_load();
        test_store();
        test_jalr();
        test_illegal();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
